// File: rtl/mips_cache_pkg.sv
// rtl/mips_cache_pkg.sv - shared types and constants for the data-cache bus controller
package mips_cache_pkg;

    // Controller sequencing states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_REQ = 3'd1,
        FILL   = 3'd2,
        WR_REQ = 3'd3,
        DONE   = 3'd4
    } ctrl_state_t;

    // Clears the byte offset so every bus access is word aligned
    localparam logic [31:0] WORD_ALIGN = 32'hFFFF_FFFC;

    // Default width of the performance counters
    localparam int CNT_W_DEFAULT = 32;

endpackage

// File: rtl/mips_sat_counter.sv
// rtl/mips_sat_counter.sv - saturating event counter
module mips_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    localparam logic [CNT_W-1:0] ALL_ONES = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

    // Count qualified events, holding at all-ones instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (inc && (q != ALL_ONES)) begin
            q <= q + ONE;
        end
    end

endmodule

// File: rtl/mips_cache_controller.sv
// rtl/mips_cache_controller.sv - miss fill and write-through sequencer between CPU, data cache and memory bus
import mips_cache_pkg::*;

module mips_cache_controller #(
    parameter int WAIT_LIMIT = 0,
    parameter int CNT_W      = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      cpu_addr,
    input  logic             cpu_read,
    input  logic             cpu_write,
    input  logic [31:0]      cpu_writedata,
    input  logic [3:0]       cpu_byteenable,
    output logic             cpu_stall,
    input  logic             cache_stall,
    output logic [31:0]      data_in,
    output logic             data_valid,
    output logic [31:0]      avm_address,
    output logic             avm_read,
    output logic             avm_write,
    output logic [31:0]      avm_writedata,
    output logic [3:0]       avm_byteenable,
    input  logic             avm_waitrequest,
    input  logic [31:0]      avm_readdata,
    output logic             bus_err,
    output logic [CNT_W-1:0] miss_cnt,
    output logic [CNT_W-1:0] wr_cnt
);

    // Last permitted wait cycle index; unused when the watchdog is off
    localparam logic [31:0] WAIT_LAST = 32'(WAIT_LIMIT - 1);
    localparam bit          WDOG_ON   = (WAIT_LIMIT != 0);

    ctrl_state_t state;
    logic        lat_write;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;
    logic [31:0] wait_cnt;
    logic        timeout;

    assign timeout = WDOG_ON && avm_waitrequest && (wait_cnt == WAIT_LAST);

    // Stall covers cache misses, active bus phases and an unaccepted store in IDLE.
    // A simultaneous load wins over the store, so the store term is masked by cpu_read.
    assign cpu_stall = cache_stall
                     | (state == RD_REQ) | (state == FILL) | (state == WR_REQ)
                     | ((state == IDLE) & cpu_write & ~cpu_read);

    // Sequencer: latches the request, drives registered bus/fill outputs, runs the watchdog
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            lat_write      <= 1'b0;
            lat_wdata      <= '0;
            lat_be         <= '0;
            wait_cnt       <= '0;
            avm_address    <= '0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_writedata  <= '0;
            avm_byteenable <= '0;
            data_in        <= '0;
            data_valid     <= 1'b0;
            bus_err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_read && cache_stall) begin
                        lat_write      <= 1'b0;
                        avm_address    <= cpu_addr & WORD_ALIGN;
                        avm_byteenable <= 4'hF;
                        avm_read       <= 1'b1;
                        wait_cnt       <= '0;
                        state          <= RD_REQ;
                    end else if (cpu_write && !cpu_read) begin
                        lat_write   <= 1'b1;
                        lat_wdata   <= cpu_writedata;
                        lat_be      <= cpu_byteenable;
                        avm_address <= cpu_addr & WORD_ALIGN;
                        wait_cnt    <= '0;
                        if (cache_stall) begin
                            avm_byteenable <= 4'hF;
                            avm_read       <= 1'b1;
                            state          <= RD_REQ;
                        end else begin
                            avm_writedata  <= cpu_writedata;
                            avm_byteenable <= cpu_byteenable;
                            avm_write      <= 1'b1;
                            state          <= WR_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    if (!avm_waitrequest) begin
                        avm_read   <= 1'b0;
                        data_in    <= avm_readdata;
                        data_valid <= 1'b1;
                        state      <= FILL;
                    end else if (timeout) begin
                        avm_read <= 1'b0;
                        bus_err  <= 1'b1;
                        state    <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                FILL: begin
                    data_valid <= 1'b0;
                    data_in    <= '0;
                    if (lat_write) begin
                        avm_writedata  <= lat_wdata;
                        avm_byteenable <= lat_be;
                        avm_write      <= 1'b1;
                        wait_cnt       <= '0;
                        state          <= WR_REQ;
                    end else begin
                        state <= DONE;
                    end
                end
                WR_REQ: begin
                    if (!avm_waitrequest) begin
                        avm_write <= 1'b0;
                        state     <= DONE;
                    end else if (timeout) begin
                        avm_write <= 1'b0;
                        bus_err   <= 1'b1;
                        state     <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    mips_sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
        .clk (clk),
        .rst (rst),
        .inc (state == FILL),
        .q   (miss_cnt)
    );

    mips_sat_counter #(.CNT_W(CNT_W)) u_wr_cnt (
        .clk (clk),
        .rst (rst),
        .inc ((state == WR_REQ) && !avm_waitrequest),
        .q   (wr_cnt)
    );

endmodule

// File: tb/tb_mips_cache_controller.sv
// tb/tb_mips_cache_controller.sv - self-checking bench for mips_cache_controller
module tb_mips_cache_controller;

    localparam int WL  = 4;
    localparam int CW  = 3;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   cpu_addr = '0;
    logic          cpu_read = 1'b0;
    logic          cpu_write = 1'b0;
    logic [31:0]   cpu_writedata = '0;
    logic [3:0]    cpu_byteenable = '0;
    logic          cpu_stall;
    logic          cache_stall = 1'b0;
    logic [31:0]   data_in;
    logic          data_valid;
    logic [31:0]   avm_address;
    logic          avm_read;
    logic          avm_write;
    logic [31:0]   avm_writedata;
    logic [3:0]    avm_byteenable;
    logic          avm_waitrequest = 1'b0;
    logic [31:0]   avm_readdata = '0;
    logic          bus_err;
    logic [CW-1:0] miss_cnt;
    logic [CW-1:0] wr_cnt;

    int passed = 0;
    int total  = 0;
    int m_miss = 0;
    int m_wr   = 0;

    mips_cache_controller #(.WAIT_LIMIT(WL), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .cpu_addr        (cpu_addr),
        .cpu_read        (cpu_read),
        .cpu_write       (cpu_write),
        .cpu_writedata   (cpu_writedata),
        .cpu_byteenable  (cpu_byteenable),
        .cpu_stall       (cpu_stall),
        .cache_stall     (cache_stall),
        .data_in         (data_in),
        .data_valid      (data_valid),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .bus_err         (bus_err),
        .miss_cnt        (miss_cnt),
        .wr_cnt          (wr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic int sat(input int v);
        return (v > SAT) ? SAT : v;
    endfunction

    // kind: 0 read hit, 1 read miss, 2 write hit, 3 write miss, 4 read+write on a miss
    task automatic run_op(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int rw, input int ww, input logic [31:0] rdata);
        bit          is_miss, is_wr, fin;
        int          exp_stall, nst, nrd, nwr, nfill, rl, wl;
        logic [31:0] exp_addr;
        is_miss   = (kind == 1) || (kind == 3) || (kind == 4);
        is_wr     = (kind == 2) || (kind == 3);
        exp_stall = (kind == 0) ? 0 : (kind == 2) ? 2 + ww : (kind == 3) ? 4 + rw + ww : 3 + rw;
        exp_addr  = {addr[31:2], 2'b00};
        nst = 0; nrd = 0; nwr = 0; nfill = 0; rl = rw; wl = ww; fin = 0;
        @(negedge clk);
        cpu_addr       = addr;
        cpu_read       = (kind == 0) || (kind == 1) || (kind == 4);
        cpu_write      = (kind == 2) || (kind == 3) || (kind == 4);
        cpu_writedata  = wdata;
        cpu_byteenable = be;
        cache_stall    = is_miss;
        for (int cyc = 0; cyc < 60; cyc++) begin
            #1;
            if (!cpu_stall) begin
                fin = 1;
                break;
            end
            nst++;
            if (avm_read) begin
                check("rd_addr", avm_address, exp_addr);
                check("rd_be", {28'd0, avm_byteenable}, 32'hF);
                check("rd_excl", {31'd0, avm_write}, 32'd0);
                if (rl > 0) begin
                    avm_waitrequest = 1'b1;
                    rl--;
                end else begin
                    avm_waitrequest = 1'b0;
                    avm_readdata    = rdata;
                    nrd++;
                end
            end else if (avm_write) begin
                check("wr_addr", avm_address, exp_addr);
                check("wr_be", {28'd0, avm_byteenable}, {28'd0, be});
                check("wr_data", avm_writedata, wdata);
                check("wr_after_rd", nrd, is_miss ? 1 : 0);
                if (wl > 0) begin
                    avm_waitrequest = 1'b1;
                    wl--;
                end else begin
                    avm_waitrequest = 1'b0;
                    nwr++;
                end
            end else begin
                avm_waitrequest = 1'b0;
            end
            if (data_valid) begin
                check("fill_data", data_in, rdata);
                nfill++;
                cache_stall = 1'b0;
            end
            @(negedge clk);
        end
        cpu_read        = 1'b0;
        cpu_write       = 1'b0;
        cache_stall     = 1'b0;
        avm_waitrequest = 1'b0;
        if (is_miss) m_miss++;
        if (is_wr)   m_wr++;
        check("op_finished", {31'd0, fin}, 32'd1);
        check("stall_cycles", nst, exp_stall);
        check("bus_reads", nrd, is_miss ? 1 : 0);
        check("bus_writes", nwr, is_wr ? 1 : 0);
        check("fills", nfill, is_miss ? 1 : 0);
        check("miss_cnt", {29'd0, miss_cnt}, sat(m_miss));
        check("wr_cnt", {29'd0, wr_cnt}, sat(m_wr));
    endtask

    initial begin
        int nrd, nfill;
        bit got;

        // Reset state
        #2;
        check("rst_avm_read", {31'd0, avm_read}, 32'd0);
        check("rst_avm_write", {31'd0, avm_write}, 32'd0);
        check("rst_data_valid", {31'd0, data_valid}, 32'd0);
        check("rst_bus_err", {31'd0, bus_err}, 32'd0);
        check("rst_miss_cnt", {29'd0, miss_cnt}, 32'd0);
        check("rst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        run_op(1, 32'h0000_0100, 32'h0, 4'h0, 0, 0, 32'hDEAD_BEEF);
        run_op(2, 32'h0000_0204, 32'h1234_5678, 4'b0011, 0, 0, 32'h0);
        run_op(3, 32'h0000_0300, 32'hCAFE_F00D, 4'b1000, 3, 3, 32'h5555_AAAA);
        run_op(4, 32'h0000_0403, 32'h0BAD_0BAD, 4'hF, 1, 0, 32'h0F0F_0F0F);
        run_op(0, 32'h0000_0010, 32'h0, 4'h0, 0, 0, 32'h0);

        // Randomized traffic, long enough to saturate the narrow counters
        for (int i = 0; i < 30; i++) begin
            run_op(int'($urandom_range(0, 4)), $urandom, $urandom, 4'($urandom_range(1, 15)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
        end

        // Watchdog: read waitrequest stuck high
        nrd = 0; nfill = 0; got = 0;
        @(negedge clk);
        cpu_addr = 32'h0000_0440; cpu_read = 1'b1; cache_stall = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            #1;
            if (bus_err) begin
                got = 1;
                break;
            end
            if (avm_read) begin
                nrd++;
                avm_waitrequest = 1'b1;
            end
            if (data_valid) nfill++;
            @(negedge clk);
        end
        check("wdog_flag", {31'd0, got}, 32'd1);
        check("wdog_wait_cycles", nrd, WL);
        check("wdog_read_dropped", {31'd0, avm_read}, 32'd0);
        check("wdog_no_fill", nfill + int'(data_valid), 0);
        cpu_read = 1'b0; cache_stall = 1'b0; avm_waitrequest = 1'b0;
        @(negedge clk);
        #1;
        check("wdog_released", {31'd0, cpu_stall}, 32'd0);
        check("wdog_sticky", {31'd0, bus_err}, 32'd1);
        check("wdog_miss_cnt", {29'd0, miss_cnt}, sat(m_miss));

        // Asynchronous reset in the middle of a write-through
        got = 0;
        @(negedge clk);
        cpu_addr = 32'h0000_0500; cpu_write = 1'b1; cpu_writedata = 32'h1111_2222;
        cpu_byteenable = 4'hF; avm_waitrequest = 1'b1;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            if (avm_write) begin
                got = 1;
                break;
            end
        end
        check("rst_mid_wr_seen", {31'd0, got}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_wr_drop", {31'd0, avm_write}, 32'd0);
        check("rst_mid_miss_cnt", {29'd0, miss_cnt}, 32'd0);
        check("rst_mid_wr_cnt", {29'd0, wr_cnt}, 32'd0);
        check("rst_mid_bus_err", {31'd0, bus_err}, 32'd0);
        cpu_write = 1'b0; avm_waitrequest = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_miss = 0; m_wr = 0;
        run_op(2, 32'h0000_0508, 32'hA5A5_5A5A, 4'b0110, 0, 1, 32'h0);
        run_op(1, 32'h0000_0600, 32'h0, 4'h0, 2, 0, 32'h7777_8888);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
